// File: rtl/ld_st_q_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ld_st_q_issue_pkg
// Purpose  : Shared types and constants for the load/store queue issue
//            controller: entry record, head FSM states, RV32 funct3
//            encodings and access-size codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ld_st_q_issue_pkg;

  localparam int LSQ_ROB_W = 5;
  localparam int LSQ_DEPTH = 32;

  // RV32 load/store funct3 encodings. Bit 2 selects zero-extension for loads.
  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;
  localparam logic [2:0] c_f3_sb  = 3'b000;
  localparam logic [2:0] c_f3_sh  = 3'b001;
  localparam logic [2:0] c_f3_sw  = 3'b010;

  // Access size is funct3[1:0].
  localparam logic [1:0] c_sz_byte = 2'b00;
  localparam logic [1:0] c_sz_half = 2'b01;
  localparam logic [1:0] c_sz_word = 2'b10;

  typedef struct packed {
    logic [LSQ_ROB_W-1:0] rob_idx;
    logic                 is_store;
    logic [2:0]           funct3;
    logic [31:0]          addr;
    logic [31:0]          sdata;
    logic                 addr_v;
    logic                 sdata_v;
  } ls_entry_t;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_OPS    = 3'd1,
    S_ST_READY    = 3'd2,
    S_WAIT_COMMIT = 3'd3,
    S_MEM         = 3'd4,
    S_BCAST       = 3'd5
  } ls_state_e;

endpackage
`default_nettype wire

// File: rtl/ld_st_q_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : ld_st_q_issue_if
// Purpose  : Bundles the dispatch, operand-update, commit, data-memory and
//            CDB signals of the load/store queue issue controller.
// Modports : slave  - the issue controller
//            master - the surrounding pipeline / memory environment
// Revision : 1.0 - initial release
// ============================================================================
interface ld_st_q_issue_if #(
  parameter int ROB_W = 5,
  parameter int DEPTH = 32
);
  localparam int PTR_W = $clog2(DEPTH);

  // dispatch
  logic             alloc_valid;
  logic [ROB_W-1:0] alloc_rob_idx;
  logic             alloc_is_store;
  logic [2:0]       alloc_funct3;
  logic             alloc_ready;
  logic [PTR_W-1:0] alloc_slot;
  // operand updates
  logic             addr_wr_valid;
  logic [DEPTH-1:0] addr_wr_onehot;
  logic [31:0]      addr_wr_value;
  logic             sdata_wr_valid;
  logic [DEPTH-1:0] sdata_wr_onehot;
  logic [31:0]      sdata_wr_value;
  // commit
  logic             rob_head_valid;
  logic [ROB_W-1:0] rob_head_idx;
  logic             st_ready_valid;
  logic [ROB_W-1:0] st_ready_rob_idx;
  // data memory
  logic             mem_read;
  logic             mem_write;
  logic [31:0]      mem_address;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_byte_enable;
  logic [31:0]      mem_rdata;
  logic             mem_resp;
  // result bus
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_idx;
  logic [31:0]      cdb_value;
  logic             empty;

  modport slave (
    input  alloc_valid, alloc_rob_idx, alloc_is_store, alloc_funct3,
    input  addr_wr_valid, addr_wr_onehot, addr_wr_value,
    input  sdata_wr_valid, sdata_wr_onehot, sdata_wr_value,
    input  rob_head_valid, rob_head_idx, mem_rdata, mem_resp,
    output alloc_ready, alloc_slot, st_ready_valid, st_ready_rob_idx,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output cdb_valid, cdb_rob_idx, cdb_value, empty
  );

  modport master (
    output alloc_valid, alloc_rob_idx, alloc_is_store, alloc_funct3,
    output addr_wr_valid, addr_wr_onehot, addr_wr_value,
    output sdata_wr_valid, sdata_wr_onehot, sdata_wr_value,
    output rob_head_valid, rob_head_idx, mem_rdata, mem_resp,
    input  alloc_ready, alloc_slot, st_ready_valid, st_ready_rob_idx,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  cdb_valid, cdb_rob_idx, cdb_value, empty
  );
endinterface
`default_nettype wire

// File: rtl/ld_st_q_issue_align.sv
`default_nettype none
// ============================================================================
// Module   : ld_st_align
// Purpose  : Combinational lane logic for one data-memory access.
// Ports    : funct3_i  - RV32 size/sign code
//            addr_lo_i - low two address bits (byte lane)
//            sdata_i   - store data (LSB-justified)
//            rdata_i   - raw memory read word
//            be_o      - byte-lane mask
//            wdata_o   - store data replicated into every lane
//            ld_val_o  - extracted, sign/zero-extended load value
// Revision : 1.0 - initial release
// ============================================================================
module ld_st_align
  import ld_st_q_issue_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_val_o
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    be_o     = 4'b1111;
    wdata_o  = sdata_i;
    ld_val_o = rdata_i;
    w_byte   = rdata_i[{addr_lo_i, 3'b000} +: 8];
    w_half   = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i[1:0])
      c_sz_byte: begin
        be_o     = 4'b0001 << addr_lo_i;
        wdata_o  = {4{sdata_i[7:0]}};
        ld_val_o = funct3_i[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      c_sz_half: begin
        // Half accesses are assumed aligned; addr bit 0 is ignored.
        be_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o  = {2{sdata_i[15:0]}};
        ld_val_o = funct3_i[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        be_o     = 4'b1111;
        wdata_o  = sdata_i;
        ld_val_o = rdata_i;
      end
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/ld_st_q_issue.sv
`default_nettype none
// ============================================================================
// Module   : ld_st_q_issue
// Purpose  : In-order issue controller for the load/store queue. Holds the
//            circular head/tail pointers and per-entry operand state, and
//            drives the single outstanding data-memory transaction for the
//            head entry. Loads broadcast on the CDB; stores wait for commit.
// Ports    : clk - clock
//            rst - synchronous active-high reset
//            bus - ld_st_q_issue_if.slave (dispatch, operand writes, commit,
//                  data memory, CDB, empty)
// Revision : 1.0 - initial release
// ============================================================================
module ld_st_q_issue
  import ld_st_q_issue_pkg::*;
#(
  parameter int ROB_W = LSQ_ROB_W,   // must match the entry record tag width
  parameter int DEPTH = LSQ_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  ld_st_q_issue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PTR_W:0] head_q, head_d, tail_q, tail_d;
  ls_state_e      state_q, state_d;
  ls_entry_t      ent_q [DEPTH];
  logic [31:0]    ld_val_q;

  ls_entry_t   w_head;
  logic        w_idx_eq, w_full, w_empty, w_alloc, w_pop, w_empty_after_pop;
  logic        w_in_mem, w_mem_write;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld_val;

  assign w_idx_eq = head_q[PTR_W-1:0] == tail_q[PTR_W-1:0];
  assign w_full   = w_idx_eq && (head_q[PTR_W] != tail_q[PTR_W]);
  assign w_empty  = w_idx_eq && (head_q[PTR_W] == tail_q[PTR_W]);
  assign w_alloc  = bus.alloc_valid && !w_full;
  assign w_head   = ent_q[head_q[PTR_W-1:0]];

  assign tail_d = tail_q + {{PTR_W{1'b0}}, w_alloc};
  assign head_d = head_q + {{PTR_W{1'b0}}, w_pop};
  // Uses the post-allocate tail so a same-cycle dispatch keeps the FSM busy.
  assign w_empty_after_pop = (head_q + {{PTR_W{1'b0}}, 1'b1}) == tail_d;

  ld_st_align u_align (
    .funct3_i  (w_head.funct3),
    .addr_lo_i (w_head.addr[1:0]),
    .sdata_i   (w_head.sdata),
    .rdata_i   (bus.mem_rdata),
    .be_o      (w_be),
    .wdata_o   (w_wdata),
    .ld_val_o  (w_ld_val)
  );

  // Entry array: operand writes first, then allocation so a same-slot
  // allocate overrides a stale operand write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.addr_wr_valid && bus.addr_wr_onehot[i]) begin
          ent_q[i].addr   <= bus.addr_wr_value;
          ent_q[i].addr_v <= 1'b1;
        end
        if (bus.sdata_wr_valid && bus.sdata_wr_onehot[i]) begin
          ent_q[i].sdata   <= bus.sdata_wr_value;
          ent_q[i].sdata_v <= 1'b1;
        end
        if (w_alloc && (tail_q[PTR_W-1:0] == PTR_W'(i))) begin
          ent_q[i].rob_idx  <= bus.alloc_rob_idx;
          ent_q[i].is_store <= bus.alloc_is_store;
          ent_q[i].funct3   <= bus.alloc_funct3;
          ent_q[i].addr_v   <= 1'b0;
          ent_q[i].sdata_v  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      state_q  <= S_IDLE;
      ld_val_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      state_q <= state_d;
      if (w_in_mem && !w_head.is_store && bus.mem_resp) ld_val_q <= w_ld_val;
    end
  end

  always_comb begin
    state_d = state_q;
    w_pop   = 1'b0;
    case (state_q)
      S_IDLE: if (!w_empty) state_d = S_WAIT_OPS;
      S_WAIT_OPS: begin
        if (w_head.is_store) begin
          if (w_head.addr_v && w_head.sdata_v) state_d = S_ST_READY;
        end else if (w_head.addr_v) begin
          state_d = S_MEM;
        end
      end
      S_ST_READY: state_d = S_WAIT_COMMIT;
      S_WAIT_COMMIT: begin
        if (bus.rob_head_valid && (bus.rob_head_idx == w_head.rob_idx))
          state_d = S_MEM;
      end
      S_MEM: begin
        if (bus.mem_resp) begin
          if (w_head.is_store) begin
            w_pop   = 1'b1;
            state_d = w_empty_after_pop ? S_IDLE : S_WAIT_OPS;
          end else begin
            state_d = S_BCAST;
          end
        end
      end
      S_BCAST: begin
        w_pop   = 1'b1;
        state_d = w_empty_after_pop ? S_IDLE : S_WAIT_OPS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are gated by state so idle values are all zero.
  assign w_in_mem    = state_q == S_MEM;
  assign w_mem_write = w_in_mem && w_head.is_store;

  assign bus.mem_read         = w_in_mem && !w_head.is_store;
  assign bus.mem_write        = w_mem_write;
  assign bus.mem_address      = w_in_mem ? {w_head.addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_byte_enable  = w_in_mem ? w_be : 4'd0;
  assign bus.mem_wdata        = w_mem_write ? w_wdata : 32'd0;
  assign bus.st_ready_valid   = state_q == S_ST_READY;
  assign bus.st_ready_rob_idx = (state_q == S_ST_READY) ? w_head.rob_idx : '0;
  assign bus.cdb_valid        = state_q == S_BCAST;
  assign bus.cdb_rob_idx      = (state_q == S_BCAST) ? w_head.rob_idx : '0;
  assign bus.cdb_value        = (state_q == S_BCAST) ? ld_val_q : 32'd0;
  assign bus.alloc_ready      = !w_full;
  assign bus.alloc_slot       = tail_q[PTR_W-1:0];
  assign bus.empty            = w_empty;
endmodule
`default_nettype wire

// File: tb/tb_ld_st_q_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ld_st_q_issue
// Purpose  : Self-checking bench for ld_st_q_issue: a table of load vectors
//            plus hand-written store, full/wrap, multi-hit update and
//            reset-abort sequences. Load results are checked through a
//            scoreboard queue drained by a CDB monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ld_st_q_issue;
  import ld_st_q_issue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ld_st_q_issue_if #(.ROB_W(5), .DEPTH(32)) bus ();

  ld_st_q_issue #(.ROB_W(5), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] val;
  } sb_t;

  typedef struct {
    logic [4:0]  tag;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_val;
  } ld_vec_t;

  sb_t     sb_q[$];
  ld_vec_t vecs[6];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      tb_tail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // CDB monitor: every broadcast must match the oldest expected load.
  always @(negedge clk) begin
    sb_t e;
    if (rst === 1'b0 && bus.cdb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL cdb_unexpected: got tag %0d value 0x%08h, expected no broadcast",
                 bus.cdb_rob_idx, bus.cdb_value);
      end else begin
        e = sb_q.pop_front();
        check("cdb_tag", 32'(bus.cdb_rob_idx), 32'(e.tag));
        check("cdb_value", bus.cdb_value, e.val);
      end
    end
  end

  task automatic clear_inputs;
    bus.alloc_valid = 1'b0; bus.alloc_rob_idx = '0; bus.alloc_is_store = 1'b0;
    bus.alloc_funct3 = '0;
    bus.addr_wr_valid = 1'b0; bus.addr_wr_onehot = '0; bus.addr_wr_value = '0;
    bus.sdata_wr_valid = 1'b0; bus.sdata_wr_onehot = '0; bus.sdata_wr_value = '0;
    bus.rob_head_valid = 1'b0; bus.rob_head_idx = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tb_tail = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},       32'(bus.empty), 32'd1);
    check({tag, "_alloc_ready"}, 32'(bus.alloc_ready), 32'd1);
    check({tag, "_alloc_slot"},  32'(bus.alloc_slot), 32'd0);
    check({tag, "_st_ready"},    32'(bus.st_ready_valid), 32'd0);
    check({tag, "_mem_read"},    32'(bus.mem_read), 32'd0);
    check({tag, "_mem_write"},   32'(bus.mem_write), 32'd0);
    check({tag, "_mem_addr"},    bus.mem_address, 32'd0);
    check({tag, "_mem_be"},      32'(bus.mem_byte_enable), 32'd0);
    check({tag, "_cdb_valid"},   32'(bus.cdb_valid), 32'd0);
    check({tag, "_cdb_value"},   bus.cdb_value, 32'd0);
  endtask

  task automatic alloc(input logic [4:0] tag, input logic st, input logic [2:0] f3,
                       output int slot);
    check("alloc_slot", 32'(bus.alloc_slot), 32'(tb_tail));
    slot = tb_tail;
    bus.alloc_valid = 1'b1; bus.alloc_rob_idx = tag;
    bus.alloc_is_store = st; bus.alloc_funct3 = f3;
    tick;
    bus.alloc_valid = 1'b0;
    tb_tail = (tb_tail + 1) % 32;
  endtask

  task automatic wr_ops(input logic [31:0] onehot, input logic [31:0] a,
                        input logic do_s, input logic [31:0] s);
    bus.addr_wr_valid = 1'b1; bus.addr_wr_onehot = onehot; bus.addr_wr_value = a;
    bus.sdata_wr_valid = do_s; bus.sdata_wr_onehot = onehot; bus.sdata_wr_value = s;
    tick;
    bus.addr_wr_valid = 1'b0; bus.sdata_wr_valid = 1'b0;
  endtask

  // Waits for the load request, checks it, answers two cycles later and
  // expects the broadcast in the following cycle.
  task automatic serve_load(input logic [4:0] tag, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_val, output int waited);
    waited = 0;
    while (bus.mem_read !== 1'b1 && waited < 20) begin
      tick;
      waited++;
    end
    if (bus.mem_read !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL mem_read_timeout: got no mem_read after %0d cycles, expected one", waited);
      return;
    end
    check("mem_address", bus.mem_address, exp_addr);
    check("mem_be", 32'(bus.mem_byte_enable), 32'(exp_be));
    check("mem_write_on_load", 32'(bus.mem_write), 32'd0);
    sb_q.push_back('{tag, exp_val});
    tick;
    tick;
    check("mem_read_held", 32'(bus.mem_read), 32'd1);
    bus.mem_resp = 1'b1; bus.mem_rdata = rdata;
    tick;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    check("mem_read_drop", 32'(bus.mem_read), 32'd0);
    check("cdb_valid_on_time", 32'(bus.cdb_valid), 32'd1);
    tick;
    check("cdb_pulse_end", 32'(bus.cdb_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int slot, n;

    vecs[0] = '{5'd3, c_f3_lw,  32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF};
    vecs[1] = '{5'd4, c_f3_lb,  32'h103, 32'h80123456, 32'h100, 4'b1000, 32'hFFFFFF80};
    vecs[2] = '{5'd5, c_f3_lbu, 32'h103, 32'h80123456, 32'h100, 4'b1000, 32'h00000080};
    vecs[3] = '{5'd6, c_f3_lh,  32'h202, 32'h9ABC1234, 32'h200, 4'b1100, 32'hFFFF9ABC};
    vecs[4] = '{5'd8, c_f3_lhu, 32'h200, 32'h1234F00D, 32'h200, 4'b0011, 32'h0000F00D};
    vecs[5] = '{5'd9, c_f3_lb,  32'h301, 32'h11227F44, 32'h300, 4'b0010, 32'h0000007F};

    clear_inputs();
    do_reset();
    check_reset_outputs("reset");

    // Table-driven loads, each issued from an empty queue.
    for (int i = 0; i < 6; i++) begin
      alloc(vecs[i].tag, 1'b0, vecs[i].f3, slot);
      wr_ops(32'd1 << slot, vecs[i].addr, 1'b0, 32'd0);
      serve_load(vecs[i].tag, vecs[i].rdata, vecs[i].exp_addr, vecs[i].exp_be,
                 vecs[i].exp_val, n);
      check("issue_latency", 32'(n), 32'd1);
      check("empty_after_load", 32'(bus.empty), 32'd1);
    end

    // Store: ready pulse, hold until its tag reaches the ROB head.
    do_reset();
    alloc(5'd7, 1'b1, c_f3_sh, slot);
    wr_ops(32'd1 << slot, 32'h202, 1'b1, 32'h1234);
    n = 0;
    while (bus.st_ready_valid !== 1'b1 && n < 10) begin tick; n++; end
    check("st_ready_valid", 32'(bus.st_ready_valid), 32'd1);
    check("st_ready_tag", 32'(bus.st_ready_rob_idx), 32'd7);
    check("st_no_write_early", 32'(bus.mem_write), 32'd0);
    tick;
    check("st_ready_pulse", 32'(bus.st_ready_valid), 32'd0);
    bus.rob_head_valid = 1'b1; bus.rob_head_idx = 5'd6;
    tick;
    tick;
    check("st_wait_wrong_tag", 32'(bus.mem_write), 32'd0);
    bus.rob_head_idx = 5'd7;
    n = 0;
    while (bus.mem_write !== 1'b1 && n < 5) begin tick; n++; end
    check("st_mem_write", 32'(bus.mem_write), 32'd1);
    check("st_mem_read", 32'(bus.mem_read), 32'd0);
    check("st_address", bus.mem_address, 32'h200);
    check("st_be", 32'(bus.mem_byte_enable), 32'hC);
    check("st_wdata", bus.mem_wdata, 32'h12341234);
    tick;
    check("st_write_held", 32'(bus.mem_write), 32'd1);
    bus.mem_resp = 1'b1;
    tick;
    bus.mem_resp = 1'b0; bus.rob_head_valid = 1'b0;
    check("st_write_drop", 32'(bus.mem_write), 32'd0);
    check("st_empty", 32'(bus.empty), 32'd1);
    check("st_no_cdb", 32'(bus.cdb_valid), 32'd0);

    // Fill all 32 entries, reject an allocate while full, pop one, wrap.
    do_reset();
    for (int i = 0; i < 32; i++) alloc(5'(i), 1'b0, c_f3_lw, slot);
    check("full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    bus.alloc_valid = 1'b1; bus.alloc_rob_idx = 5'd31; bus.alloc_is_store = 1'b0;
    tick;
    bus.alloc_valid = 1'b0;
    check("full_reject_slot", 32'(bus.alloc_slot), 32'd0);
    check("full_reject_ready", 32'(bus.alloc_ready), 32'd0);
    wr_ops(32'h1, 32'h500, 1'b0, 32'd0);
    serve_load(5'd0, 32'hCAFEF00D, 32'h500, 4'b1111, 32'hCAFEF00D, n);
    check("pop_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    alloc(5'd20, 1'b0, c_f3_lw, slot);
    check("wrap_slot", 32'(slot), 32'd0);
    check("refull_alloc_ready", 32'(bus.alloc_ready), 32'd0);

    // One address write with two one-hot bits feeds two entries.
    do_reset();
    alloc(5'd10, 1'b0, c_f3_lw, slot);
    alloc(5'd11, 1'b0, c_f3_lw, slot);
    wr_ops(32'h3, 32'h400, 1'b0, 32'd0);
    serve_load(5'd10, 32'h11111111, 32'h400, 4'b1111, 32'h11111111, n);
    serve_load(5'd11, 32'h22222222, 32'h400, 4'b1111, 32'h22222222, n);
    check("multi_empty", 32'(bus.empty), 32'd1);

    // Reset during MEM aborts the access; the late response is ignored.
    do_reset();
    alloc(5'd12, 1'b0, c_f3_lw, slot);
    wr_ops(32'd1 << slot, 32'h600, 1'b0, 32'd0);
    n = 0;
    while (bus.mem_read !== 1'b1 && n < 10) begin tick; n++; end
    check("abort_mem_read_seen", 32'(bus.mem_read), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tb_tail = 0;
    check_reset_outputs("abort");
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    tick;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    check("abort_no_cdb", 32'(bus.cdb_valid), 32'd0);
    tick;
    check("abort_no_cdb_late", 32'(bus.cdb_valid), 32'd0);
    check("abort_mem_idle", 32'(bus.mem_read), 32'd0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
